ir_queue: RTL and testbench
===========================

Name: ir_queue

Overview:
- Parametrised successor to the single-word instruction register.
- Sits between instruction memory fetch and the control unit.
- Buffers up to DEPTH fetched words with their PCs in a FIFO. A registered "current instruction" stage is loaded from the FIFO head on IRWre.
- Decodes the current instruction into MIPS fields and adds valid/ready handshaking and a flush for branches and jumps.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, ≥2.
- PC_WIDTH, 32, width of PC tag carried with each word.
- CNT_WIDTH, $clog2(DEPTH)+1, width of occupancy count.

Ports:
- CLK  in  1  rising-edge clock
- RST_n  in  1  asynchronous active-low reset
- In_valid  in  1  fetch word present on Data_in/PC_in
- In_ready  out  1  queue accepts a word this cycle
- Data_in  in  32  fetched instruction word
- PC_in  in  PC_WIDTH  address of Data_in
- IRWre  in  1  advance: load head into current instruction register
- Flush  in  1  discard all queued words and invalidate current instruction
- Ins_valid  out  1  current instruction register holds a live instruction
- Ins_Data  out  32  current instruction word
- PC_out  out  PC_WIDTH  PC of current instruction
- Op_code  out  6  Ins_Data[31:26]
- Rs_reg  out  5  Ins_Data[25:21]
- Rt_reg  out  5  Ins_Data[20:16]
- Rd_reg  out  5  Ins_Data[15:11]
- Sa_number  out  5  Ins_Data[10:6]
- Funct  out  6  Ins_Data[5:0]
- Imm_number  out  16  Ins_Data[15:0]
- Addr_number  out  26  Ins_Data[25:0]
- Count  out  CNT_WIDTH  FIFO occupancy (excludes current register)
- Underrun  out  1  one-cycle pulse: IRWre seen with FIFO empty

Behaviour:
- Reset (RST_n=0, async):
  - Read/write pointers, Count, Ins_Data, PC_out, Ins_valid and Underrun all go to 0.
  - All decoded fields therefore read 0.
- In_ready = (Count < DEPTH) && !Flush. It is combinational and does not depend on In_valid.
- Push: In_valid && In_ready at a rising edge.
  - The word and PC are written at the write pointer; the pointer increments and wraps modulo DEPTH.
- Pop: IRWre && Count>0 && !Flush at a rising edge.
  - The head word and PC go to Ins_Data/PC_out and Ins_valid<=1.
  - The read pointer increments and wraps modulo DEPTH.
- Latency and bypass:
  - A pushed word is poppable the cycle after the push.
  - There is no empty-queue bypass: a push and IRWre on the same edge with Count=0 gives Underrun=1 and Ins_valid<=0, and the word lands in the FIFO.
- IRWre with Count=0 and !Flush:
  - Ins_valid<=0; Ins_Data/PC_out hold their previous value; Underrun=1 for one cycle.
- IRWre=0: current register holds unchanged, as the original IR did.
- Push and pop on the same edge:
  - Count is unchanged and both pointers advance.
  - Legal at any 0<Count<DEPTH. At Count=DEPTH no push is possible because In_ready=0.
- Count tracking: Count increments on push-only and decrements on pop-only. It never exceeds DEPTH and never goes below 0.
- Flush has highest priority.
  - Pointers and Count go to 0 and Ins_valid<=0.
  - Ins_Data/PC_out hold their previous value.
  - A simultaneous push or IRWre is ignored (In_ready is already 0). Underrun stays 0.
- Decoded fields are combinational slices of Ins_Data only and never of the FIFO head.
- Reset mid-operation: all state clears immediately. Any partially handshaked word is lost.
- FIFO storage itself needs no reset; only pointers and valid state are reset.

Decomposition:
- Shared package ir_pkg holds:
  - field bit-position constants: OP_MSB/LSB, RS_MSB/LSB, RT_*, RD_*, SA_*, FUNCT_*, IMM_*, ADDR_*
  - INS_WIDTH=32
- One natural sub-module: ir_fifo.
  - Parametrised DEPTH x (32+PC_WIDTH) circular buffer with push, pop, flush and count.
  - It is instantiated by ir_queue, which adds the current-instruction stage, underrun detection and field decode.

Test Plan:
- Reset: assert RST_n=0 mid-cycle, asynchronously.
  - Required: all outputs 0 immediately, In_ready=1.
- Fill and drain, DEPTH=4: push 0x8C220004@PC 0x00, 0x00430820@0x04, 0x08000010@0x08, 0x1000FFFF@0x0C.
  - After the fourth push: Count=4, In_ready=0.
  - Pop 1: Op_code=0x23, Rs=1, Rt=2, Imm=0x0004, PC_out=0x00.
  - Pop 2: Rd=1, Funct=0x20.
  - Pop 3: Addr_number=0x0000010.
- Wrap-around: run 10 push/pop pairs on the same edges with Count held at 2.
  - Required: FIFO order preserved across pointer wrap, Count constant at 2.
- Underrun: with Count=0, pulse IRWre.
  - Required: Underrun=1 for exactly 1 cycle, Ins_valid=0, Ins_Data unchanged.
- Flush priority: with Count=3, Ins_valid=1, assert Flush together with In_valid and IRWre.
  - Required next cycle: Count=0, Ins_valid=0, no push accepted, Underrun=0, Ins_Data held.
- Full backpressure: with Count=4, hold In_valid=1 for 3 cycles, then one pop.
  - Required: no writes while full. The held word is accepted on the cycle after the pop; Count returns to 4.

Source files
------------

// File: rtl/ir_pkg.sv
// Shared constants for the instruction queue: MIPS field bit positions
// and the instruction word width.
package ir_pkg;

   localparam int INS_WIDTH = 32;

   // Field boundaries within a 32-bit MIPS instruction word
   localparam int OP_MSB    = 31;
   localparam int OP_LSB    = 26;
   localparam int RS_MSB    = 25;
   localparam int RS_LSB    = 21;
   localparam int RT_MSB    = 20;
   localparam int RT_LSB    = 16;
   localparam int RD_MSB    = 15;
   localparam int RD_LSB    = 11;
   localparam int SA_MSB    = 10;
   localparam int SA_LSB    = 6;
   localparam int FUNCT_MSB = 5;
   localparam int FUNCT_LSB = 0;
   localparam int IMM_MSB   = 15;
   localparam int IMM_LSB   = 0;
   localparam int ADDR_MSB  = 25;
   localparam int ADDR_LSB  = 0;

endpackage : ir_pkg

// File: rtl/ir_fifo.sv
// Circular buffer of DEPTH instruction words, each tagged with its PC.
// The caller gates push/pop against full/empty; flush empties the buffer.
module ir_fifo
   import ir_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int PC_WIDTH  = 32,
   parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
   input  logic                 CLK,
   input  logic                 RST_n,
   input  logic                 push,
   input  logic                 pop,
   input  logic                 flush,
   input  logic [INS_WIDTH-1:0] wr_data,
   input  logic [PC_WIDTH-1:0]  wr_pc,
   output logic [INS_WIDTH-1:0] rd_data,
   output logic [PC_WIDTH-1:0]  rd_pc,
   output logic [CNT_WIDTH-1:0] count,
   output logic                 full,
   output logic                 empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int ENT_W = INS_WIDTH + PC_WIDTH;

   logic [ENT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Write the incoming word and its PC at the tail
   // NOTE: storage carries no reset; only pointers and count define which entries are live.
   always_ff @(posedge CLK) begin
      if (push) begin
         mem[wr_ptr] <= {wr_data, wr_pc};
      end
   end

   // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of 2
   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      count <= count + CNT_WIDTH'(1);
         else if (pop && !push) count <= count - CNT_WIDTH'(1);
      end
   end

   assign {rd_data, rd_pc} = mem[rd_ptr];
   assign full  = (count == CNT_WIDTH'(DEPTH));
   assign empty = (count == '0);

endmodule : ir_fifo

// File: rtl/ir_queue.sv
// Instruction queue: FIFO of fetched words feeding a registered current
// instruction stage, with handshaking, flush, underrun flag and MIPS decode.
module ir_queue
   import ir_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int PC_WIDTH  = 32,
   parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
   input  logic                 CLK,
   input  logic                 RST_n,
   input  logic                 In_valid,
   output logic                 In_ready,
   input  logic [INS_WIDTH-1:0] Data_in,
   input  logic [PC_WIDTH-1:0]  PC_in,
   input  logic                 IRWre,
   input  logic                 Flush,
   output logic                 Ins_valid,
   output logic [INS_WIDTH-1:0] Ins_Data,
   output logic [PC_WIDTH-1:0]  PC_out,
   output logic [5:0]           Op_code,
   output logic [4:0]           Rs_reg,
   output logic [4:0]           Rt_reg,
   output logic [4:0]           Rd_reg,
   output logic [4:0]           Sa_number,
   output logic [5:0]           Funct,
   output logic [15:0]          Imm_number,
   output logic [25:0]          Addr_number,
   output logic [CNT_WIDTH-1:0] Count,
   output logic                 Underrun
);

   logic                 fifo_push;
   logic                 fifo_pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [INS_WIDTH-1:0] head_data;
   logic [PC_WIDTH-1:0]  head_pc;

   // Flush blocks both handshakes; a pop needs a non-empty queue
   assign In_ready  = !fifo_full && !Flush;
   assign fifo_push = In_valid && In_ready;
   assign fifo_pop  = IRWre && !fifo_empty && !Flush;

   ir_fifo #(
      .DEPTH     (DEPTH),
      .PC_WIDTH  (PC_WIDTH),
      .CNT_WIDTH (CNT_WIDTH)
   ) u_fifo (
      .CLK     (CLK),
      .RST_n   (RST_n),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .flush   (Flush),
      .wr_data (Data_in),
      .wr_pc   (PC_in),
      .rd_data (head_data),
      .rd_pc   (head_pc),
      .count   (Count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Current instruction stage: load head on advance, invalidate on flush or empty advance
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         Ins_valid <= 1'b0;
         Ins_Data  <= '0;
         PC_out    <= '0;
         Underrun  <= 1'b0;
      end else begin
         Underrun <= IRWre && fifo_empty && !Flush;
         if (Flush) begin
            Ins_valid <= 1'b0;
         end else if (IRWre) begin
            Ins_valid <= !fifo_empty;
            if (!fifo_empty) begin
               Ins_Data <= head_data;
               PC_out   <= head_pc;
            end
         end
      end
   end

   // Field decode is taken from the current instruction only, never the FIFO head
   assign Op_code     = Ins_Data[OP_MSB:OP_LSB];
   assign Rs_reg      = Ins_Data[RS_MSB:RS_LSB];
   assign Rt_reg      = Ins_Data[RT_MSB:RT_LSB];
   assign Rd_reg      = Ins_Data[RD_MSB:RD_LSB];
   assign Sa_number   = Ins_Data[SA_MSB:SA_LSB];
   assign Funct       = Ins_Data[FUNCT_MSB:FUNCT_LSB];
   assign Imm_number  = Ins_Data[IMM_MSB:IMM_LSB];
   assign Addr_number = Ins_Data[ADDR_MSB:ADDR_LSB];

endmodule : ir_queue

// File: tb/tb_ir_queue.sv
// Scoreboard bench for ir_queue: a queue-based reference model predicts every
// pop; a monitor compares each instruction the DUT loads against it.
module tb_ir_queue;

   localparam int DEPTH     = 4;
   localparam int PC_WIDTH  = 32;
   localparam int CNT_WIDTH = $clog2(DEPTH) + 1;

   logic                 CLK;
   logic                 RST_n;
   logic                 In_valid;
   logic                 In_ready;
   logic [31:0]          Data_in;
   logic [PC_WIDTH-1:0]  PC_in;
   logic                 IRWre;
   logic                 Flush;
   logic                 Ins_valid;
   logic [31:0]          Ins_Data;
   logic [PC_WIDTH-1:0]  PC_out;
   logic [5:0]           Op_code;
   logic [4:0]           Rs_reg;
   logic [4:0]           Rt_reg;
   logic [4:0]           Rd_reg;
   logic [4:0]           Sa_number;
   logic [5:0]           Funct;
   logic [15:0]          Imm_number;
   logic [25:0]          Addr_number;
   logic [CNT_WIDTH-1:0] Count;
   logic                 Underrun;

   ir_queue #(.DEPTH(DEPTH), .PC_WIDTH(PC_WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
      .CLK(CLK), .RST_n(RST_n), .In_valid(In_valid), .In_ready(In_ready),
      .Data_in(Data_in), .PC_in(PC_in), .IRWre(IRWre), .Flush(Flush),
      .Ins_valid(Ins_valid), .Ins_Data(Ins_Data), .PC_out(PC_out),
      .Op_code(Op_code), .Rs_reg(Rs_reg), .Rt_reg(Rt_reg), .Rd_reg(Rd_reg),
      .Sa_number(Sa_number), .Funct(Funct), .Imm_number(Imm_number),
      .Addr_number(Addr_number), .Count(Count), .Underrun(Underrun)
   );

   typedef struct {
      logic [31:0]         w;
      logic [PC_WIDTH-1:0] pc;
   } item_t;

   item_t mq[$];          // reference FIFO contents
   item_t sb[$];          // expected loads awaiting the monitor
   item_t cur;            // expected current instruction
   logic  exp_valid;
   logic  exp_under;
   int    n_vec;
   int    n_err;
   logic [PC_WIDTH-1:0] next_pc;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish (got running, need finished)");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: whenever an advance lands on a live instruction, compare it to the scoreboard head
   initial begin
      logic ir_s, fl_s;
      item_t e;
      forever begin
         @(posedge CLK);
         ir_s = IRWre;
         fl_s = Flush;
         #1;
         if (RST_n && ir_s && !fl_s && Ins_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_load", 64'(Ins_Data), 64'(32'hDEAD_BEEF));
            end else begin
               e = sb.pop_front();
               check("ld_data",  64'(Ins_Data),    64'(e.w));
               check("ld_pc",    64'(PC_out),      64'(e.pc));
               check("ld_op",    64'(Op_code),     64'((e.w >> 26) & 32'h3F));
               check("ld_rs",    64'(Rs_reg),      64'((e.w >> 21) & 32'h1F));
               check("ld_rt",    64'(Rt_reg),      64'((e.w >> 16) & 32'h1F));
               check("ld_rd",    64'(Rd_reg),      64'((e.w >> 11) & 32'h1F));
               check("ld_sa",    64'(Sa_number),   64'((e.w >> 6) & 32'h1F));
               check("ld_funct", 64'(Funct),       64'(e.w & 32'h3F));
               check("ld_imm",   64'(Imm_number),  64'(e.w & 32'hFFFF));
               check("ld_addr",  64'(Addr_number), 64'(e.w & 32'h03FF_FFFF));
            end
         end
      end
   end

   // One clock of stimulus, with the reference model advanced at the edge
   task automatic step(input logic v, input logic [31:0] d, input logic [PC_WIDTH-1:0] pc,
                       input logic ir, input logic fl);
      bit acc, pop;
      item_t it;
      @(negedge CLK);
      In_valid = v;
      Data_in  = d;
      PC_in    = pc;
      IRWre    = ir;
      Flush    = fl;
      #1;
      check("in_ready", 64'(In_ready), 64'(mq.size() < DEPTH && !fl));
      @(posedge CLK);
      exp_under = ir && !fl && mq.size() == 0;
      if (fl) begin
         mq.delete();
         exp_valid = 1'b0;
      end else begin
         acc = v && mq.size() < DEPTH;
         pop = ir && mq.size() > 0;
         if (ir) exp_valid = pop;
         if (pop) begin
            it = mq.pop_front();
            sb.push_back(it);
            cur = it;
         end
         if (acc) begin
            it.w  = d;
            it.pc = pc;
            mq.push_back(it);
         end
      end
      #1;
      check("count",     64'(Count),     64'(mq.size()));
      check("ins_valid", 64'(Ins_valid), 64'(exp_valid));
      check("underrun",  64'(Underrun),  64'(exp_under));
      check("ins_data",  64'(Ins_Data),  64'(cur.w));
      check("pc_out",    64'(PC_out),    64'(cur.pc));
   endtask

   task automatic push_word(input logic [31:0] d, input logic [PC_WIDTH-1:0] pc);
      step(1'b1, d, pc, 1'b0, 1'b0);
   endtask

   task automatic pop_word();
      step(1'b0, 32'h0, '0, 1'b1, 1'b0);
   endtask

   task automatic check_reset_outputs();
      check("rst_ins_valid", 64'(Ins_valid), 64'(0));
      check("rst_ins_data",  64'(Ins_Data),  64'(0));
      check("rst_pc_out",    64'(PC_out),    64'(0));
      check("rst_count",     64'(Count),     64'(0));
      check("rst_underrun",  64'(Underrun),  64'(0));
      check("rst_op",        64'(Op_code),   64'(0));
      check("rst_addr",      64'(Addr_number), 64'(0));
      check("rst_in_ready",  64'(In_ready),  64'(1));
   endtask

   task automatic clear_model();
      mq.delete();
      sb.delete();
      cur.w = '0;
      cur.pc = '0;
      exp_valid = 1'b0;
      exp_under = 1'b0;
   endtask

   initial begin
      logic [31:0] held;
      logic [31:0] w;
      n_vec = 0;
      n_err = 0;
      next_pc = '0;
      RST_n = 1'b0;
      In_valid = 1'b0;
      Data_in = '0;
      PC_in = '0;
      IRWre = 1'b0;
      Flush = 1'b0;
      clear_model();
      #12;
      check_reset_outputs();
      @(negedge CLK);
      RST_n = 1'b1;

      // Fill and drain
      push_word(32'h8C22_0004, 32'h00);
      push_word(32'h0043_0820, 32'h04);
      push_word(32'h0800_0010, 32'h08);
      push_word(32'h1000_FFFF, 32'h0C);
      check("full_count", 64'(Count), 64'(4));
      check("full_ready", 64'(In_ready), 64'(0));
      pop_word();
      check("p1_op",  64'(Op_code),    64'(6'h23));
      check("p1_rs",  64'(Rs_reg),     64'(1));
      check("p1_rt",  64'(Rt_reg),     64'(2));
      check("p1_imm", 64'(Imm_number), 64'(16'h0004));
      check("p1_pc",  64'(PC_out),     64'(32'h00));
      pop_word();
      check("p2_rd",    64'(Rd_reg), 64'(1));
      check("p2_funct", 64'(Funct),  64'(6'h20));
      pop_word();
      check("p3_addr", 64'(Addr_number), 64'(26'h0000010));

      // Wrap-around: keep two entries while pushing and popping together
      push_word(32'hA000_0000, 32'h10);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 32'hB000_0000 + 32'(i), 32'h100 + 32'(i * 4), 1'b1, 1'b0);
         check("wrap_count", 64'(Count), 64'(2));
      end

      // Underrun
      pop_word();
      pop_word();
      held = Ins_Data;
      pop_word();
      check("ur_pulse", 64'(Underrun),  64'(1));
      check("ur_valid", 64'(Ins_valid), 64'(0));
      check("ur_held",  64'(Ins_Data),  64'(held));
      step(1'b0, 32'h0, '0, 1'b0, 1'b0);
      check("ur_once",  64'(Underrun),  64'(0));

      // Same-edge push and advance on an empty queue: underrun, word stored
      step(1'b1, 32'hC0FF_EE00, 32'h200, 1'b1, 1'b0);
      check("bypass_ur",  64'(Underrun), 64'(1));
      check("bypass_cnt", 64'(Count),    64'(1));
      pop_word();

      // Flush priority
      for (int i = 0; i < 4; i++) push_word(32'hD000_0000 + 32'(i), 32'h300 + 32'(i * 4));
      pop_word();
      held = Ins_Data;
      check("fl_pre_cnt", 64'(Count), 64'(3));
      step(1'b1, 32'hEEEE_EEEE, 32'h400, 1'b1, 1'b1);
      check("fl_count", 64'(Count),     64'(0));
      check("fl_valid", 64'(Ins_valid), 64'(0));
      check("fl_under", 64'(Underrun),  64'(0));
      check("fl_held",  64'(Ins_Data),  64'(held));

      // Full backpressure
      for (int i = 0; i < 4; i++) push_word(32'hF000_0000 + 32'(i), 32'h500 + 32'(i * 4));
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 32'h1234_5678, 32'h600, 1'b0, 1'b0);
         check("bp_count", 64'(Count), 64'(4));
      end
      step(1'b1, 32'h1234_5678, 32'h600, 1'b1, 1'b0);
      step(1'b1, 32'h1234_5678, 32'h600, 1'b0, 1'b0);
      check("bp_refill", 64'(Count), 64'(4));
      for (int i = 0; i < 4; i++) pop_word();
      check("bp_last", 64'(Ins_Data), 64'(32'h1234_5678));

      // Randomized traffic
      next_pc = 32'h1000;
      for (int i = 0; i < 400; i++) begin
         w = $urandom;
         step(1'($urandom_range(0, 3) != 0), w, next_pc,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 29) == 0));
         next_pc = next_pc + 32'd4;
      end

      // Asynchronous reset mid-cycle
      @(negedge CLK);
      In_valid = 1'b1;
      IRWre = 1'b0;
      Flush = 1'b0;
      #2;
      RST_n = 1'b0;
      #1;
      In_valid = 1'b0;
      #1;
      check_reset_outputs();
      clear_model();
      @(negedge CLK);
      RST_n = 1'b1;
      push_word(32'h2108_0001, 32'h40);
      pop_word();
      pop_word();

      check("sb_drained", 64'(sb.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_ir_queue
